// File: rtl/medidor_frec_multi.sv
// Purpose : multi-channel frequency meter; counts rising edges of N_CH async inputs over a 2^resol-cycle gate.
// Latency : valid pulses 2^resol clock cycles after the cycle in which start is sampled; results held until next window.
// Backpr. : none; valid is a 1-cycle pulse with no ready, and start is ignored while a window is in progress.
module medidor_frec_multi #(
  parameter int N_CH      = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [4:0]                    resol,
  input  logic [N_CH-1:0]               clock_u,
  output logic                          busy,
  output logic                          valid,
  output logic                          lock,
  output logic [N_CH*CNT_WIDTH-1:0]     out,
  output logic [N_CH-1:0]               ovf
);

  typedef enum logic {IDLE, GATE} state_t;

  state_t               state;
  logic [4:0]           resol_q;
  logic [31:0]          timebase;
  logic [31:0]          last_tb;
  logic                 win_end;

  // s1/s2 form the synchroniser, s3 is the history bit for edge detection
  logic [N_CH-1:0]      s1;
  logic [N_CH-1:0]      s2;
  logic [N_CH-1:0]      s3;
  logic [N_CH-1:0]      rise;

  logic [CNT_WIDTH-1:0] cnt     [N_CH];
  logic [CNT_WIDTH-1:0] cnt_nxt [N_CH];
  logic [N_CH-1:0]      sat;
  logic [N_CH-1:0]      sat_nxt;

  assign rise    = s2 & ~s3;
  assign last_tb = (32'd1 << resol_q) - 32'd1;
  assign win_end = (state == GATE) && (timebase == last_tb);

  // Bring the measured signals into the clock domain and keep one cycle of history
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= clock_u;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Saturating increment per channel; an edge arriving at all-ones is lost and flagged
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = cnt[i];
      sat_nxt[i] = sat[i];
      if (rise[i]) begin
        if (&cnt[i]) begin
          sat_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Gate FSM: owns timebase, edge counters, result registers and status outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      resol_q  <= '0;
      timebase <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      lock     <= 1'b0;
      out      <= '0;
      ovf      <= '0;
      sat      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        // Abort has priority over everything, including a window that ends this cycle;
        // results already reported stay visible
        state    <= IDLE;
        busy     <= 1'b0;
        lock     <= 1'b0;
        timebase <= '0;
        sat      <= '0;
        for (int i = 0; i < N_CH; i++) begin
          cnt[i] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (start) begin
              resol_q  <= resol;
              timebase <= '0;
              sat      <= '0;
              for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
              end
              state <= GATE;
              busy  <= 1'b1;
            end
          end
          GATE: begin
            if (win_end) begin
              // The last gate cycle's edges go straight into the result so no edge is dropped
              for (int i = 0; i < N_CH; i++) begin
                out[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_nxt[i];
                cnt[i] <= '0;
              end
              ovf      <= sat_nxt;
              sat      <= '0;
              valid    <= 1'b1;
              lock     <= 1'b1;
              timebase <= '0;
              if (continuous) begin
                // Back-to-back windows: next gate starts on the very next cycle
                resol_q <= resol;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              timebase <= timebase + 32'd1;
              sat      <= sat_nxt;
              for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
